// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game sequencer.
// Board bit 0 is the top-left cell and the cells run in row-major order.
package ttt_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WIN   = 2'd2,
        ST_DRAW  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int NUM_LINES = 8;

    // The rows, then the columns, then the two diagonals.
    localparam logic [8:0] LINE_MASK [0:NUM_LINES-1] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    localparam logic [8:0] BOARD_FULL = 9'h1FF;

    function automatic logic is_onehot9(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win detector for one player's board.
// mask is the union of every completed line, so a double win lights both lines.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0] board,
    output logic       line_hit,
    output logic [8:0] mask
);

    always_comb begin
        mask     = 9'd0;
        line_hit = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if ((board & LINE_MASK[i]) == LINE_MASK[i]) begin
                mask     = mask | LINE_MASK[i];
                line_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_game_sequencer.sv
// Tic-tac-toe game controller: board ownership, turn order, move legality,
// one-cycle win/draw evaluation and saturating per-player score counters.
module ttt_game_sequencer
    import ttt_pkg::*;
#(
    parameter int SCORE_W   = 4,
    parameter bit ALT_START = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [8:0]         cell_sel,
    output logic [8:0]         board_x,
    output logic [8:0]         board_o,
    output logic               cur_player,
    output logic               busy,
    output logic               move_err,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [8:0]         win_mask,
    output logic [SCORE_W-1:0] score_x,
    output logic [SCORE_W-1:0] score_o
);

    state_t     state, state_next;
    logic       start_player;
    logic       start_next;
    logic [8:0] occupied;
    logic [8:0] mover_board;
    logic [8:0] line_mask;
    logic       line_hit;
    logic       accept, reject, do_win, do_draw, do_toggle;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

    assign occupied    = board_x | board_o;
    // cur_player only toggles after CHECK, so during CHECK it still names the mover.
    assign mover_board = cur_player ? board_o : board_x;
    assign start_next  = ALT_START ? ~start_player : 1'b0;

    assign busy      = (state == ST_CHECK);
    assign game_over = (state == ST_WIN) || (state == ST_DRAW);

    ttt_line_check u_line_check (
        .board    (mover_board),
        .line_hit (line_hit),
        .mask     (line_mask)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_PLAY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        do_win     = 1'b0;
        do_draw    = 1'b0;
        do_toggle  = 1'b0;
        if (new_game) begin
            state_next = ST_PLAY;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (move_valid) begin
                        if (is_onehot9(cell_sel) && ((occupied & cell_sel) == 9'd0)) begin
                            accept     = 1'b1;
                            state_next = ST_CHECK;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    // A line completed on the last empty cell is a win, not a draw.
                    if (line_hit) begin
                        do_win     = 1'b1;
                        state_next = ST_WIN;
                    end else if (occupied == BOARD_FULL) begin
                        do_draw    = 1'b1;
                        state_next = ST_DRAW;
                    end else begin
                        do_toggle  = 1'b1;
                        state_next = ST_PLAY;
                    end
                end
                ST_WIN, ST_DRAW: state_next = state;
                default:         state_next = ST_PLAY;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            board_x      <= 9'd0;
            board_o      <= 9'd0;
            cur_player   <= 1'b0;
            start_player <= 1'b0;
            move_err     <= 1'b0;
            winner       <= WIN_NONE;
            win_mask     <= 9'd0;
            score_x      <= '0;
            score_o      <= '0;
        end else begin
            move_err <= reject;
            if (new_game) begin
                board_x      <= 9'd0;
                board_o      <= 9'd0;
                winner       <= WIN_NONE;
                win_mask     <= 9'd0;
                start_player <= start_next;
                cur_player   <= start_next;
            end else begin
                if (accept) begin
                    if (cur_player) board_o <= board_o | cell_sel;
                    else            board_x <= board_x | cell_sel;
                end
                if (do_toggle) cur_player <= ~cur_player;
                if (do_win) begin
                    winner   <= cur_player ? WIN_O : WIN_X;
                    win_mask <= line_mask;
                    if (cur_player) score_o <= sat_inc(score_o);
                    else            score_x <= sat_inc(score_x);
                end
                if (do_draw) winner <= WIN_DRAW;
            end
        end
    end

endmodule

// File: tb/tb_ttt_game_sequencer.sv
// Directed bench for ttt_game_sequencer with hand-computed expectations.
module tb_ttt_game_sequencer;

    localparam int SCORE_W = 4;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               new_game;
    logic               move_valid;
    logic [8:0]         cell_sel;
    logic [8:0]         board_x, board_o, win_mask;
    logic               cur_player, busy, move_err, game_over;
    logic [1:0]         winner;
    logic [SCORE_W-1:0] score_x, score_o;

    int   vectors     = 0;
    int   miscompares = 0;
    logic tb_start    = 1'b0;

    ttt_game_sequencer #(.SCORE_W(SCORE_W), .ALT_START(1'b1)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .new_game   (new_game),
        .move_valid (move_valid),
        .cell_sel   (cell_sel),
        .board_x    (board_x),
        .board_o    (board_o),
        .cur_player (cur_player),
        .busy       (busy),
        .move_err   (move_err),
        .game_over  (game_over),
        .winner     (winner),
        .win_mask   (win_mask),
        .score_x    (score_x),
        .score_o    (score_o)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic move_acc(input logic [8:0] c);
        move_valid = 1'b1;
        cell_sel   = c;
        @(negedge Clk);
        move_valid = 1'b0;
        cell_sel   = 9'd0;
        chk("busy_in_check", busy, 1);
        chk("no_err_on_accept", move_err, 0);
        @(negedge Clk);
        chk("busy_one_cycle", busy, 0);
    endtask

    task automatic move_rej(input logic [8:0] c);
        move_valid = 1'b1;
        cell_sel   = c;
        @(negedge Clk);
        move_valid = 1'b0;
        cell_sel   = 9'd0;
        chk("err_pulse", move_err, 1);
        chk("no_busy_on_reject", busy, 0);
        @(negedge Clk);
        chk("err_one_cycle", move_err, 0);
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge Clk);
        new_game = 1'b0;
        tb_start = ~tb_start;
        chk("ng_board_x", board_x, 0);
        chk("ng_board_o", board_o, 0);
        chk("ng_winner", winner, 0);
        chk("ng_win_mask", win_mask, 0);
        chk("ng_game_over", game_over, 0);
        chk("ng_start_player", cur_player, tb_start);
    endtask

    task automatic start_game_x();
        pulse_new_game();
        if (tb_start) pulse_new_game();
    endtask

    initial begin
        Reset      = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        cell_sel   = 9'd0;
        repeat (2) @(negedge Clk);
        chk("rst_board_x", board_x, 0);
        chk("rst_board_o", board_o, 0);
        chk("rst_cur_player", cur_player, 0);
        chk("rst_winner", winner, 0);
        chk("rst_win_mask", win_mask, 0);
        chk("rst_move_err", move_err, 0);
        chk("rst_score_x", score_x, 0);
        chk("rst_score_o", score_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_game_over", game_over, 0);
        Reset = 1'b0;
        @(negedge Clk);

        // X takes the top row
        move_acc(9'h001);
        move_acc(9'h008);
        move_acc(9'h002);
        move_acc(9'h010);
        move_acc(9'h004);
        chk("t1_winner", winner, 2'b01);
        chk("t1_win_mask", win_mask, 9'h007);
        chk("t1_score_x", score_x, 1);
        chk("t1_score_o", score_o, 0);
        chk("t1_game_over", game_over, 1);
        chk("t1_cur_player", cur_player, 0);
        chk("t1_board_x", board_x, 9'h007);
        chk("t1_board_o", board_o, 9'h018);

        // moves are ignored once the game is decided
        move_valid = 1'b1;
        cell_sel   = 9'h100;
        @(negedge Clk);
        move_valid = 1'b0;
        cell_sel   = 9'd0;
        chk("t4_no_err", move_err, 0);
        chk("t4_board_x", board_x, 9'h007);
        chk("t4_board_o", board_o, 9'h018);
        chk("t4_winner", winner, 2'b01);
        chk("t4_game_over", game_over, 1);
        pulse_new_game();
        chk("t4_o_starts", cur_player, 1);
        chk("t4_score_kept", score_x, 1);

        // illegal moves
        pulse_new_game();
        move_acc(9'h010);
        chk("t2_turn_o", cur_player, 1);
        move_rej(9'h010);
        chk("t2_board_o", board_o, 9'h000);
        chk("t2_still_o", cur_player, 1);
        move_rej(9'h003);
        move_rej(9'h000);
        move_acc(9'h001);
        chk("t2_board_o_after", board_o, 9'h001);
        chk("t2_back_to_x", cur_player, 0);

        // full-board draw
        start_game_x();
        move_acc(9'h001);
        move_acc(9'h002);
        move_acc(9'h004);
        move_acc(9'h010);
        move_acc(9'h008);
        move_acc(9'h040);
        move_acc(9'h020);
        move_acc(9'h100);
        move_acc(9'h080);
        chk("t3_winner", winner, 2'b11);
        chk("t3_win_mask", win_mask, 0);
        chk("t3_score_x", score_x, 1);
        chk("t3_score_o", score_o, 0);
        chk("t3_game_over", game_over, 1);

        // last move completes a line and fills the board; also a move during CHECK
        start_game_x();
        move_valid = 1'b1;
        cell_sel   = 9'h001;
        @(negedge Clk);
        cell_sel   = 9'h002;
        chk("chk_busy", busy, 1);
        @(negedge Clk);
        move_valid = 1'b0;
        cell_sel   = 9'd0;
        chk("chk_move_ignored_o", board_o, 0);
        chk("chk_move_ignored_x", board_x, 9'h001);
        chk("chk_move_no_err", move_err, 0);
        chk("chk_turn_o", cur_player, 1);
        move_acc(9'h002);
        move_acc(9'h004);
        move_acc(9'h010);
        move_acc(9'h080);
        move_acc(9'h020);
        move_acc(9'h008);
        move_acc(9'h100);
        move_acc(9'h040);
        chk("fw_winner", winner, 2'b01);
        chk("fw_win_mask", win_mask, 9'h049);
        chk("fw_score_x", score_x, 2);
        chk("fw_full", board_x | board_o, 9'h1FF);

        // new_game together with move_valid drops the move
        start_game_x();
        new_game   = 1'b1;
        move_valid = 1'b1;
        cell_sel   = 9'h001;
        @(negedge Clk);
        new_game   = 1'b0;
        move_valid = 1'b0;
        cell_sel   = 9'd0;
        tb_start   = ~tb_start;
        chk("t6a_board_x", board_x, 0);
        chk("t6a_board_o", board_o, 0);
        chk("t6a_no_err", move_err, 0);
        chk("t6a_busy", busy, 0);
        chk("t6a_cur_player", cur_player, tb_start);

        // new_game during CHECK on a winning move discards the win
        start_game_x();
        move_acc(9'h001);
        move_acc(9'h008);
        move_acc(9'h002);
        move_acc(9'h010);
        move_valid = 1'b1;
        cell_sel   = 9'h004;
        @(negedge Clk);
        move_valid = 1'b0;
        cell_sel   = 9'd0;
        chk("t6b_busy", busy, 1);
        new_game = 1'b1;
        @(negedge Clk);
        new_game = 1'b0;
        tb_start = ~tb_start;
        chk("t6b_board_x", board_x, 0);
        chk("t6b_winner", winner, 0);
        chk("t6b_score_x", score_x, 2);
        chk("t6b_game_over", game_over, 0);
        chk("t6b_busy", busy, 0);
        chk("t6b_cur_player", cur_player, tb_start);
        @(negedge Clk);
        chk("t6b_score_hold", score_x, 2);
        chk("t6b_winner_hold", winner, 0);

        // score saturation
        for (int i = 0; i < 16; i++) begin
            start_game_x();
            move_acc(9'h001);
            move_acc(9'h008);
            move_acc(9'h002);
            move_acc(9'h010);
            move_acc(9'h004);
            chk("t5_score_x", score_x, (3 + i > 15) ? 15 : 3 + i);
        end
        chk("t5_score_o", score_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
